alarm_unit: RTL and testbench
=============================

Name: alarm_unit

Overview:
- Alarm stage sitting directly downstream of the real-time clock. Consumes the running BCD time `data_ch` (HHMMSS) and the shared debounced button pulses.
- Holds a user-set alarm time HH:MM and exposes it as `data_a` for the display mux.
- Drives a blinking `led` pattern while ringing.
- Active only when the mode counter `rezhim` equals `ALARM_REZHIM`, except for the stop action.

Parameters:
- ALARM_REZHIM, 2'd3, `rezhim` value in which alarm setup buttons are honoured.
- RING_SEC, 60, number of whole seconds the alarm rings before auto-stop (1..255).
- SNOOZE_MIN, 5, snooze delay in minutes (1..59); used only with the optional feature.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- data_ch  in  24  current time, BCD {H1,H0,M1,M0,S1,S0}
- rezhim  in  2  current UI mode
- button  in  4  single-cycle debounced pulses: [1] increment field, [2] select field / snooze, [3] arm toggle / stop; [0] is mode-advance and is ignored here
- data_a  out  24  alarm time for display, BCD {HH,MM,8'h00}
- armed  out  1  alarm enabled
- ringing  out  1  alarm currently sounding
- led  out  4  all-ones/all-zeros blink while ringing, else 4'b0000

Behaviour:
- Reset is sampled on the clock edge while `reset`==0. Reset values: alarm time 00:00, `data_a`=24'h000000, `armed`=0, `ringing`=0, `led`=0, field select=hours, ring counter=0, state=IDLE.
- Second tick:
  - Register `data_ch[3:0]` each cycle.
  - `sec_tick`=1 for exactly one cycle when the live value differs from the registered one.
  - The first cycle after reset never ticks, because the register loads during reset.
- Setup is honoured only when `rezhim`==ALARM_REZHIM and state≠RINGING:
  - `button[2]` toggles field select (hours↔minutes).
  - `button[1]` increments the selected field in BCD. Hours wrap 23→00; minutes wrap 59→00 with no carry into hours.
  - `button[3]` toggles `armed`.
  - `data_a` updates the cycle after the press.
- States:
  - IDLE: `ringing`=0. Go to RINGING when `armed` & `sec_tick` & `data_ch[23:8]`==alarm HHMM & `data_ch[7:0]`==8'h00. Ring counter is cleared on entry.
  - RINGING: `ringing`=1.
    - Ring counter increments on each `sec_tick`.
    - `led` inverts on each `sec_tick`; it starts at 4'hF on entry.
    - Exit to IDLE when the counter reaches RING_SEC, or on `button[3]` in any `rezhim`. The stop press is consumed and does not toggle `armed`.
    - `armed` stays 1 after exit, so the alarm repeats daily.
  - SNOOZE: exists only with the optional feature.
- Match is evaluated only on `sec_tick`. A time jump via setup onto HH:MM:00 with no tick does not ring.
- Simultaneous events:
  - Match and setup press in the same cycle: setup applies, match is evaluated against the pre-press alarm time.
  - `button[3]` and match in the same cycle while armed: toggle wins, `armed`→0, no ring.
- Disarming is impossible while RINGING (`button[3]` means stop there).
- Reset mid-ring returns to IDLE, disarmed, with `led`=0.
- Latency: `ringing` asserts one clock after the matching `sec_tick` cycle.

Optional Feature:
- Macro: ALARM_SNOOZE_EN.
- When defined, `button[2]` in RINGING (any `rezhim`) moves to SNOOZE.
  - Stores a target time = current HHMM + SNOOZE_MIN, in BCD with minute carry into hours and hours wrap 23→00.
  - In SNOOZE: `ringing`=0, `led`=0.
  - On `sec_tick` with `data_ch[23:8]`==target and seconds 00, go back to RINGING with the counter cleared.
  - `button[3]` in SNOOZE cancels to IDLE.
  - Snooze chains without limit.
- When not defined, `button[2]` is ignored during RINGING and SNOOZE is unreachable.

Decomposition:
- Shared package `chasy_pkg`:
  - state enum {IDLE, RINGING, SNOOZE}
  - BCD limit constants HOUR_MAX=8'h23, MIN_MAX=8'h59
  - `rezhim` encodings
- One natural sub-module, `bcd_inc_wrap`: combinational 8-bit BCD increment with parameterised max and carry-out. Used for field editing and for snooze target computation.

Test Plan:
- Set alarm 07:30, arm; drive `data_ch` 07:29:59→07:30:00 → `ringing`=1 one clock after the tick, `led`=4'hF, then toggles each second; auto-clear after 60 ticks, `armed` still 1.
- Alarm 23:59, hours select, press `button[1]` → `data_a`=24'h005900; minutes select, press `button[1]` → 24'h000000 (no carry into hours).
- Ringing, press `button[3]` with `rezhim`=0 → `ringing`=0 next cycle, `armed`=1.
- Disarmed, time passes 07:30:00 → no ring. Assert `reset` low mid-ring → all outputs return to reset values on the next edge.
- `button[3]` on the same cycle as the matching tick → `armed`=0, `ringing` stays 0.
- With ALARM_SNOOZE_EN: ring at 23:58:00, press `button[2]` → SNOOZE; advance to 00:03:00 → `ringing`=1 again.

Source files
------------

// File: rtl/chasy_pkg.sv
// Shared types and constants for the clock/alarm datapath.
package chasy_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_t;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;

    localparam logic [1:0] REZHIM_TIME      = 2'd0;
    localparam logic [1:0] REZHIM_SET       = 2'd1;
    localparam logic [1:0] REZHIM_STOPWATCH = 2'd2;
    localparam logic [1:0] REZHIM_ALARM     = 2'd3;

    // Two-digit BCD to binary (0..99).
    function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
        return 7'({3'b000, b[7:4]} * 7'd10 + {3'b000, b[3:0]});
    endfunction

    // Binary (0..99) to two-digit BCD.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

endpackage

// File: rtl/bcd_inc_wrap.sv
// Two-digit BCD increment that wraps to 00 past MAX and flags the wrap.
module bcd_inc_wrap #(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic [7:0] value,
    output logic [7:0] result_c,
    output logic       carry_c
);

    always_comb begin
        result_c = 8'h00;
        carry_c  = 1'b0;
        if (value >= MAX) begin
            carry_c = 1'b1;
        end else if (value[3:0] >= 4'd9) begin
            result_c = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result_c = {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/alarm_unit.sv
// Alarm stage: HH:MM alarm setup, daily match, timed ring with blinking LEDs.
// Optional snooze on button[2] while ringing when ALARM_SNOOZE_EN is defined.
module alarm_unit
    import chasy_pkg::*;
#(
    parameter logic [1:0]  ALARM_REZHIM = REZHIM_ALARM,
    parameter int unsigned RING_SEC     = 60,
    parameter int unsigned SNOOZE_MIN   = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] data_ch,
    input  logic [1:0]  rezhim,
    input  logic [3:0]  button,
    output logic [23:0] data_a,
    output logic        armed,
    output logic        ringing,
    output logic [3:0]  led
);

    localparam int unsigned CNT_W = 8;

    alarm_state_t     state;
    logic [3:0]       sec_prev;
    logic             sel_min;
    logic [CNT_W-1:0] ring_cnt;
    logic [CNT_W-1:0] ring_cnt_next;

    logic       sec_tick;
    logic       setup_en;
    logic       arm_toggle;
    logic       alarm_hit;
    logic [7:0] hh_inc;
    logic [7:0] mm_inc;
    logic       hh_carry_unused;
    logic       mm_carry_unused;
    logic       btn_mode_unused;

    assign btn_mode_unused = button[0];

    // Seconds digit history; loads during reset so the first cycle never ticks.
    always_ff @(posedge clock) begin
        sec_prev <= data_ch[3:0];
    end

    assign sec_tick      = (data_ch[3:0] != sec_prev);
    assign setup_en      = (rezhim == ALARM_REZHIM) && (state != RINGING);
    assign arm_toggle    = setup_en && button[3] && (state != SNOOZE);
    assign alarm_hit     = sec_tick && (data_ch[23:8] == data_a[23:8]) && (data_ch[7:0] == 8'h00);
    assign ring_cnt_next = ring_cnt + CNT_W'(1);

    bcd_inc_wrap #(.MAX(HOUR_MAX)) u_hh_inc (
        .value    (data_a[23:16]),
        .result_c (hh_inc),
        .carry_c  (hh_carry_unused)
    );

    bcd_inc_wrap #(.MAX(MIN_MAX)) u_mm_inc (
        .value    (data_a[15:8]),
        .result_c (mm_inc),
        .carry_c  (mm_carry_unused)
    );

`ifdef ALARM_SNOOZE_EN
    logic [15:0] snz_target;
    logic [15:0] snz_next;
    logic [6:0]  snz_sum;
    logic        snz_wrap;
    logic [7:0]  snz_hh_inc;
    logic        snz_hh_carry_unused;
    logic        snz_hit;

    // Wake-up time is now + SNOOZE_MIN with minute carry into hours.
    assign snz_sum  = bcd_to_bin(data_ch[15:8]) + 7'(SNOOZE_MIN);
    assign snz_wrap = (snz_sum >= 7'd60);
    assign snz_next = {snz_wrap ? snz_hh_inc : data_ch[23:16],
                       bin_to_bcd(snz_wrap ? (snz_sum - 7'd60) : snz_sum)};
    assign snz_hit  = sec_tick && (data_ch[23:8] == snz_target) && (data_ch[7:0] == 8'h00);

    bcd_inc_wrap #(.MAX(HOUR_MAX)) u_snz_hh_inc (
        .value    (data_ch[23:16]),
        .result_c (snz_hh_inc),
        .carry_c  (snz_hh_carry_unused)
    );
`else
    localparam int unsigned SNOOZE_MIN_UNUSED = SNOOZE_MIN;
`endif

    // Setup handling plus the alarm state machine.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            data_a   <= 24'h000000;
            armed    <= 1'b0;
            ringing  <= 1'b0;
            led      <= 4'h0;
            sel_min  <= 1'b0;
            ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
            snz_target <= 16'h0000;
`endif
        end else begin
            if (setup_en) begin
                if (button[2]) begin
                    sel_min <= ~sel_min;
                end
                if (button[1]) begin
                    if (sel_min) begin
                        data_a[15:8] <= mm_inc;
                    end else begin
                        data_a[23:16] <= hh_inc;
                    end
                end
            end
            if (arm_toggle) begin
                armed <= ~armed;
            end

            case (state)
                IDLE: begin
                    ringing <= 1'b0;
                    led     <= 4'h0;
                    if (armed && alarm_hit && !arm_toggle) begin
                        state    <= RINGING;
                        ringing  <= 1'b1;
                        led      <= 4'hF;
                        ring_cnt <= '0;
                    end
                end
                RINGING: begin
                    if (button[3]) begin
                        state   <= IDLE;
                        ringing <= 1'b0;
                        led     <= 4'h0;
`ifdef ALARM_SNOOZE_EN
                    end else if (button[2]) begin
                        state      <= SNOOZE;
                        ringing    <= 1'b0;
                        led        <= 4'h0;
                        snz_target <= snz_next;
`endif
                    end else if (sec_tick) begin
                        if (ring_cnt_next == CNT_W'(RING_SEC)) begin
                            state   <= IDLE;
                            ringing <= 1'b0;
                            led     <= 4'h0;
                        end else begin
                            ring_cnt <= ring_cnt_next;
                            led      <= ~led;
                        end
                    end
                end
                SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
                    ringing <= 1'b0;
                    led     <= 4'h0;
                    if (button[3]) begin
                        state <= IDLE;
                    end else if (snz_hit) begin
                        state    <= RINGING;
                        ringing  <= 1'b1;
                        led      <= 4'hF;
                        ring_cnt <= '0;
                    end
`else
                    state   <= IDLE;
                    ringing <= 1'b0;
                    led     <= 4'h0;
`endif
                end
                default: begin
                    state   <= IDLE;
                    ringing <= 1'b0;
                    led     <= 4'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit: setup, ring timing, stop, disarm, reset, collisions.
module tb_alarm_unit;

    logic        clock;
    logic        reset;
    logic [23:0] data_ch;
    logic [1:0]  rezhim;
    logic [3:0]  button;
    logic [23:0] data_a;
    logic        armed;
    logic        ringing;
    logic [3:0]  led;

    int total;
    int bad;

    alarm_unit dut (
        .clock   (clock),
        .reset   (reset),
        .data_ch (data_ch),
        .rezhim  (rezhim),
        .button  (button),
        .data_a  (data_a),
        .armed   (armed),
        .ringing (ringing),
        .led     (led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] b);
        button = b;
        step();
        button = 4'b0000;
    endtask

    task automatic press_n(input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) press(b);
    endtask

    task automatic set_time(input logic [23:0] t);
        data_ch = t;
        step();
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        data_ch = 24'h000000;
        rezhim  = 2'd0;
        button  = 4'b0000;
        step();
        step();
        check("rst_data_a", data_a, 24'h000000);
        check("rst_armed", 24'(armed), 24'd0);
        check("rst_ringing", 24'(ringing), 24'd0);
        check("rst_led", 24'(led), 24'h0);
        reset = 1'b1;
        step();

        // Alarm 07:30, armed
        rezhim = 2'd3;
        press_n(4'b0010, 7);
        check("set_hh07", data_a, 24'h070000);
        press(4'b0100);
        press_n(4'b0010, 30);
        check("set_0730", data_a, 24'h073000);
        press(4'b1000);
        check("arm_on", 24'(armed), 24'd1);
        rezhim = 2'd0;

        set_time(24'h072959);
        check("pre_match_ring", 24'(ringing), 24'd0);
        set_time(24'h073000);
        check("ring_latency", 24'(ringing), 24'd1);
        check("ring_led_start", 24'(led), 24'hF);
        for (int k = 1; k < 60; k++) begin
            set_time({16'h0730, 4'(k / 10), 4'(k % 10)});
            check("ring_hold", 24'(ringing), 24'd1);
            check("ring_blink", 24'(led), (k % 2 == 1) ? 24'h0 : 24'hF);
        end
        set_time(24'h073100);
        check("auto_stop", 24'(ringing), 24'd0);
        check("auto_stop_led", 24'(led), 24'h0);
        check("auto_stop_armed", 24'(armed), 24'd1);

        // BCD wrap: 23:59 -> hours 00:59 -> minutes 00:00
        rezhim = 2'd3;
        press(4'b0100);
        press_n(4'b0010, 16);
        press(4'b0100);
        press_n(4'b0010, 29);
        check("set_2359", data_a, 24'h235900);
        press(4'b0100);
        press(4'b0010);
        check("hh_wrap", data_a, 24'h005900);
        press(4'b0100);
        press(4'b0010);
        check("mm_wrap_nocarry", data_a, 24'h000000);

        // Stop from another mode
        rezhim = 2'd0;
        set_time(24'h235959);
        set_time(24'h000000);
        check("ring_0000", 24'(ringing), 24'd1);
        press(4'b1000);
        check("stop_ringing", 24'(ringing), 24'd0);
        check("stop_armed", 24'(armed), 24'd1);

        // Disarmed: no ring
        rezhim = 2'd3;
        press(4'b1000);
        check("disarm", 24'(armed), 24'd0);
        rezhim = 2'd0;
        set_time(24'h235959);
        set_time(24'h000000);
        check("disarmed_no_ring", 24'(ringing), 24'd0);

        // Reset mid-ring with alarm 01:00
        rezhim = 2'd3;
        press(4'b0100);
        press(4'b0010);
        press(4'b1000);
        check("set_0100", data_a, 24'h010000);
        rezhim = 2'd0;
        set_time(24'h005959);
        set_time(24'h010000);
        check("ring_0100", 24'(ringing), 24'd1);
        reset = 1'b0;
        step();
        check("midrst_data_a", data_a, 24'h000000);
        check("midrst_armed", 24'(armed), 24'd0);
        check("midrst_ringing", 24'(ringing), 24'd0);
        check("midrst_led", 24'(led), 24'h0);
        reset = 1'b1;
        step();

        // Arm toggle on the matching tick wins
        rezhim = 2'd3;
        press(4'b1000);
        check("rearm", 24'(armed), 24'd1);
        set_time(24'h235959);
        data_ch = 24'h000000;
        press(4'b1000);
        check("collide_armed", 24'(armed), 24'd0);
        check("collide_ringing", 24'(ringing), 24'd0);
        step();
        check("collide_ringing2", 24'(ringing), 24'd0);

        // Ring at 23:58, then button[2]
        press_n(4'b0010, 23);
        press(4'b0100);
        press_n(4'b0010, 58);
        press(4'b1000);
        check("set_2358", data_a, 24'h235800);
        check("arm_2358", 24'(armed), 24'd1);
        rezhim = 2'd0;
        set_time(24'h235759);
        set_time(24'h235800);
        check("ring_2358", 24'(ringing), 24'd1);
        press(4'b0100);
`ifdef ALARM_SNOOZE_EN
        check("snooze_quiet", 24'(ringing), 24'd0);
        check("snooze_led", 24'(led), 24'h0);
        set_time(24'h000259);
        set_time(24'h000300);
        check("snooze_wake", 24'(ringing), 24'd1);
        check("snooze_wake_led", 24'(led), 24'hF);
`else
        check("b2_ignored_ring", 24'(ringing), 24'd1);
        check("b2_ignored_led", 24'(led), 24'hF);
`endif
        press(4'b1000);
        check("final_stop", 24'(ringing), 24'd0);
        check("final_armed", 24'(armed), 24'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
